// File: rtl/token_run_encoder.sv
// Run-length encoder for a serial token stream: counts runs of consecutive '1's
// and queues {saturated, length} entries in a small FIFO for a ready/valid consumer.
module token_run_encoder #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [LEN_W-1:0] out_len,
    output logic             out_sat,
    output logic             overflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = LEN_W + 1;

    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             run_sat_q, run_sat_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [ENT_W-1:0] mem_q [DEPTH];

    logic             push_c;
    logic             push_ok_c;
    logic             pop_c;
    logic             full_c;
    logic [ENT_W-1:0] entry_c;
    logic [ENT_W-1:0] head_c;

    // Run counter and queue bookkeeping
    always_comb begin
        cnt_d      = cnt_q;
        run_sat_d  = run_sat_q;
        push_c     = 1'b0;
        entry_c    = {run_sat_q, cnt_q};
        if (a) begin
            if (cnt_q == '0) begin
                cnt_d     = LEN_W'(1);
                run_sat_d = 1'b0;
            end else if (&cnt_q) begin
                run_sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + LEN_W'(1);
            end
        end else if (cnt_q != '0) begin
            push_c    = 1'b1;
            cnt_d     = '0;
            run_sat_d = 1'b0;
        end

        pop_c      = (count_q != '0) && out_ready;
        full_c     = (count_q == CNT_W'(DEPTH));
        // A full queue can still accept when the head leaves on the same edge
        push_ok_c  = push_c && (!full_c || pop_c);
        wr_ptr_d   = push_ok_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
        overflow_d = overflow_q | (push_c & ~push_ok_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            run_sat_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            run_sat_q  <= run_sat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; occupancy gates visibility
    always_ff @(posedge clk) begin
        if (!rst && push_ok_c) begin
            mem_q[wr_ptr_q] <= entry_c;
        end
    end

    assign head_c    = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign out_len   = out_valid ? head_c[LEN_W-1:0] : '0;
    assign out_sat   = out_valid & head_c[LEN_W];
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_token_run_encoder.sv
// Directed self-checking bench for token_run_encoder (LEN_W=8, DEPTH=4).
module tb_token_run_encoder;

    logic       clk;
    logic       rst;
    logic       a;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_len;
    logic       out_sat;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    token_run_encoder #(.LEN_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_len   (out_len),
        .out_sat   (out_sat),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply inputs for one edge; outputs are sampled 1ns after that edge
    task automatic step(input logic r, input logic av, input logic rdy);
        rst       = r;
        a         = av;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string tag, input int unsigned len, input int unsigned sat);
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_len"}, 32'(out_len), len);
        check({tag, "_sat"}, 32'(out_sat), sat);
    endtask

    task automatic expect_empty(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_len"}, 32'(out_len), 0);
        check({tag, "_sat"}, 32'(out_sat), 0);
    endtask

    initial begin
        rst = 1'b1; a = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        step(1, 1, 1);
        step(1, 0, 0);
        expect_empty("reset");
        check("reset_ovf", 32'(overflow), 0);

        // Run of 3 with a ready consumer
        step(0, 1, 1); check("r3_c1_valid", 32'(out_valid), 0);
        step(0, 1, 1); check("r3_c2_valid", 32'(out_valid), 0);
        step(0, 1, 1); check("r3_c3_valid", 32'(out_valid), 0);
        step(0, 0, 1); expect_head("r3_head", 3, 0);
        step(0, 0, 1); expect_empty("r3_popped");

        // Three queued runs 1,1,2 then drain in order
        step(0, 1, 0);
        step(0, 0, 0); expect_head("q_first", 1, 0);
        step(0, 0, 0); expect_head("q_hold0", 1, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        step(0, 1, 0); expect_head("q_hold1", 1, 0);
        step(0, 0, 0); expect_head("q_hold2", 1, 0);
        step(0, 0, 1); expect_head("q_second", 1, 0);
        step(0, 0, 1); expect_head("q_third", 2, 0);
        step(0, 0, 1); expect_empty("q_drained");
        step(0, 0, 1); expect_empty("q_idle_ready");

        // Saturation: 300 ones clamp at 255, then a run of 2
        for (int i = 0; i < 300; i++) step(0, 1, 0);
        check("sat_novalid", 32'(out_valid), 0);
        step(0, 0, 0); expect_head("sat_head", 255, 1);
        step(0, 1, 1); expect_empty("sat_popped");
        step(0, 1, 1);
        step(0, 0, 0); expect_head("run2_head", 2, 0);
        step(0, 0, 1); expect_empty("run2_popped");

        // Overflow: five runs of 1 into a 4-deep queue
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0);
            step(0, 0, 0);
            if (i == 3) check("ovf_after4", 32'(overflow), 0);
        end
        check("ovf_after5", 32'(overflow), 1);
        for (int i = 0; i < 4; i++) begin
            expect_head($sformatf("ovf_drain%0d", i), 1, 0);
            step(0, 0, 1);
        end
        expect_empty("ovf_drained");
        check("ovf_sticky_drain", 32'(overflow), 1);
        step(0, 1, 0);
        step(0, 0, 0); expect_head("ovf_later", 1, 0);
        step(0, 0, 1);
        check("ovf_sticky_accept", 32'(overflow), 1);
        step(1, 0, 0);
        check("ovf_cleared", 32'(overflow), 0);

        // Full queue with simultaneous push and pop
        for (int len = 1; len <= 4; len++) begin
            for (int k = 0; k < len; k++) step(0, 1, 0);
            step(0, 0, 0);
        end
        expect_head("full_head", 1, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 0);
        step(0, 0, 1);
        check("full_pp_ovf", 32'(overflow), 0);
        for (int len = 2; len <= 5; len++) begin
            expect_head($sformatf("full_drain%0d", len), 32'(len), 0);
            step(0, 0, 1);
        end
        expect_empty("full_drained");

        // Reset mid-run discards the partial run
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        step(0, 0, 0);
        expect_empty("rst_midrun");
        check("rst_midrun_ovf", 32'(overflow), 0);
        step(0, 1, 0);
        step(0, 0, 0); expect_head("post_rst_run", 1, 0);
        step(0, 0, 1); expect_empty("post_rst_popped");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/token_run_encoder.md
TOKEN_RUN_ENCODER -- requirements
Module: token_run_encoder

Interface
REQ-001 Parameter LEN_W, default 8: width of run-length field; maximum recordable run is 2^LEN_W-1.
REQ-002 Parameter DEPTH, default 4: number of entries in the output queue; power of two, >=2.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a  input  1  serial token stream, one bit per cycle ('1' = token), e.g. from the token doubler.
REQ-006 out_ready  input  1  downstream accepts the current entry this cycle.
REQ-007 out_valid  output  1  queue head holds a valid entry.
REQ-008 out_len  output  LEN_W  length of the run of consecutive '1's at queue head.
REQ-009 out_sat  output  1  head run exceeded 2^LEN_W-1 tokens; out_len is clamped.
REQ-010 overflow  output  1  sticky: a completed run was dropped because the queue was full.

Function
REQ-011 Run counter cnt (LEN_W bits) shall increment on every cycle with a=1; run_sat flag shall clear at run start.
REQ-012 With cnt at 2^LEN_W-1 and a=1, cnt shall hold and run_sat shall set; no wrap-around.
REQ-013 A run shall terminate on the first cycle with a=0 while cnt>0; {cnt, run_sat} shall be pushed, then cnt and run_sat cleared.
REQ-014 a=0 with cnt=0 shall push nothing; a run still in progress shall never be pushed.
REQ-015 A terminated run shall appear at the queue output on the cycle after the terminating a=0 edge when the queue was empty (latency 1 cycle).
REQ-016 A '1' arriving the cycle after termination shall start a new run with cnt=1.
REQ-017 Queue shall be FIFO; entries emitted in run-completion order; no reordering or merging.
REQ-018 out_valid shall equal (queue not empty); out_len/out_sat shall be driven from the head entry and held stable while out_valid=1 and out_ready=0.
REQ-019 Pop shall occur on a posedge with out_valid=1 and out_ready=1; out_ready while empty shall have no effect.
REQ-020 out_len/out_sat shall be 0 when out_valid=0.
REQ-021 Push with queue full and no simultaneous pop: entry dropped, queue unchanged, overflow set.
REQ-022 Push and pop on the same edge with queue full: both succeed, occupancy stays DEPTH, overflow unchanged.
REQ-023 Push and pop on the same edge with queue empty impossible (out_valid=0); push simply proceeds.
REQ-024 overflow shall remain 1 until rst; later accepted or dropped runs do not clear it.
REQ-025 Occupancy count shall range 0..DEPTH; read/write pointers wrap modulo DEPTH.
REQ-026 Entries shall not be modified after push.

Reset
REQ-027 On rst: cnt=0, run_sat=0, queue empty, out_valid=0, out_len=0, out_sat=0, overflow=0.
REQ-028 rst mid-run shall discard the partial run; no entry pushed for it, even if a=0 follows.
REQ-029 rst shall take priority over a, out_ready and any pending push or pop on the same edge.
REQ-030 First edge after rst deasserts shall sample a normally (a=1 gives cnt=1).

Verification
REQ-031 out_ready=1, a=1,1,1,0 -> out_valid=1 one cycle after the 0 edge with out_len=3, out_sat=0; popped next edge.
REQ-032 out_ready=0, a=1,0,0,1,0,0,1,1,0 -> three entries, then out_ready=1 pops out_len 1,1,2 in order; out_valid=0 afterwards.
REQ-033 LEN_W=8, 300 consecutive a=1 then a=0 -> single entry out_len=255, out_sat=1; next run of 2 gives out_len=2, out_sat=0.
REQ-034 DEPTH=4, out_ready=0, five runs of length 1 -> entries 1..4 retained, overflow=1 after fifth terminator and stays 1 after draining, until rst.
REQ-035 Queue full, out_ready=1 on the same edge a run of length 5 terminates -> head popped, entry 5 appended last, overflow=0.
REQ-036 a=1 for 3 cycles, rst for 1 cycle, then a=0 -> no entry, out_valid=0, all outputs 0.
